ita_activation_ctrl: RTL
========================

# ita_activation_ctrl

Sequenced activation unit for ITA's feed-forward path. It accepts a one-shot configuration (activation mode, GELU constants, requantization parameters, beat count), then streams N-lane WI-bit beats through N GELU lanes. Results are requantized back to WI bits and emitted over a valid/ready stream, and completion is signalled once the final beat has been accepted downstream. It sits between the FF1 output requantizer and the FF2 input buffer.

## Interface
- N, default N (ita_package): lanes per beat.
- LEN_W, default 16: width of the beat counter.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- cfg_valid_i  in  1  configuration strobe; sampled only in IDLE.
- cfg_ready_o  out  1  high in IDLE.
- cfg_mode_i  in  2  activation mode: 0 identity, 1 GELU, 2 ReLU, 3 reserved (treated as identity).
- cfg_one_i / cfg_b_i / cfg_c_i  in  GELU_CONSTANTS_WIDTH each  signed GELU constants.
- cfg_rq_mult_i  in  8  unsigned requant multiplier.
- cfg_rq_shift_i  in  5  requant right shift.
- cfg_rq_add_i  in  WI  signed requant offset.
- cfg_len_i  in  LEN_W  beats in the job; 0 is treated as 1.
- in_valid_i / in_ready_o  in/out  1  input handshake.
- in_data_i  in  N×WI  signed lanes.
- out_valid_o / out_ready_i  out/in  1  output handshake.
- out_data_o  out  N×WI  signed lanes.
- busy_o  out  1  high in every state other than IDLE.
- done_o  out  1  single-cycle pulse on job completion.

## Operation
- States:
  - IDLE: cfg_ready_o=1. On cfg_valid_i, latch all cfg_* and load the remaining-beat counter; go to RUN.
  - RUN: accept beats. When the last beat is accepted, go to DRAIN.
  - DRAIN: in_ready_o=0. Wait until the output has accepted the beat tagged as last, then go to DONE.
  - DONE: done_o=1 for one cycle; go to IDLE.
- Beats accepted beyond cfg_len_i are impossible: in_ready_o=0 outside RUN.
- Pipeline: three stages (S0 input register, S1 activation register, S2 requant/output register). Each stage has its own valid bit plus a last tag.
- Stall rule: stage k advances iff stage k+1 is empty or advancing. S2 advances on out_ready_i. in_ready_o = (state==RUN) && S0 advancing-or-empty.
- Activation in S0→S1, per lane:
  - identity: sign-extend to GELU_OUT_WIDTH.
  - GELU: computed with the latched constants.
  - ReLU: max(x,0).
- Requant in S1→S2, per lane:
  - p = a·rq_mult, signed, full width.
  - r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
  - q = r + rq_add.
  - Saturate q to [-2^(WI-1), 2^(WI-1)-1].
- Configuration stays frozen until IDLE. A cfg_valid_i outside IDLE is ignored.

## Timing
- Latency: 3 cycles from input handshake to out_valid_o when there is no backpressure. Throughput is 1 beat/cycle.
- out_data_o holds stable while out_valid_o && !out_ready_i.
- done_o asserts the cycle after the last output handshake.
- busy_o rises the cycle after the config handshake and falls together with done_o.
- Reset values: cfg_ready_o=1, in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0. Counter, latched config and all stage valids are cleared.
- Reset asserted mid-job aborts immediately: pipeline contents are discarded and done_o is not emitted.
- In the same cycle, the last input handshake and a pending output handshake are both honoured.

## Configuration
- ITA_ACT_RELU_EN defined: mode 2 computes ReLU.
- ITA_ACT_RELU_EN undefined: the ReLU logic is absent and mode 2 behaves as identity.

## Structure
- ita_package holds:
  - act_mode_e enum (IDENTITY, GELU, RELU, RSVD);
  - act_state_e (IDLE, RUN, DRAIN, DONE);
  - requant_cfg_t struct (mult, shift, add);
  - constants WI, N, GELU_OUT_WIDTH, GELU_CONSTANTS_WIDTH.
- One sub-module: ita_gelu, instantiated N times (one per lane) and fed from S0. The mode mux and requantizer stay inline.

## Test plan
- Identity, mult=1, shift=0, add=0, len=1, lane=5: out lane=5, 3 cycles after acceptance; done_o pulses the cycle after the output handshake.
- Saturation: identity, lane=100, mult=4 → 127; lane=-100 → -128.
- Rounding: identity, lane=3, mult=1, shift=1 → 2; lane=-3 → -1.
- GELU mode, lane=0, add=7 → 7 (x·(·)=0). A len=8 stream with out_ready_i toggled every other cycle delivers 8 beats in order with no loss or duplicates, and in_ready_o drops while stalled.
- ReLU mode, lane=-5 → 0 with ITA_ACT_RELU_EN; → -5 without it.
- Reset asserted during DRAIN: all outputs return to reset values, no done_o, and a following config is accepted.

Source files
------------

// File: rtl/ita_package.sv
// ita_package
//   Shared constants and types for the ITA activation path.
//   WI                   : width of one signed lane on the input/output streams
//   N                    : lanes per beat
//   GELU_CONSTANTS_WIDTH : width of the signed GELU constants (one, b, c)
//   GELU_OUT_WIDTH       : width of a lane after activation, before requant
//   act_mode_e           : activation select (IDENTITY, GELU, RELU, RSVD)
//   act_state_e          : sequencer states (IDLE, RUN, DRAIN, DONE)
//   requant_cfg_t        : requantization parameters (mult, shift, add)
package ita_package;

    localparam int unsigned WI                   = 8;
    localparam int unsigned N                    = 4;
    localparam int unsigned GELU_CONSTANTS_WIDTH = 16;
    localparam int unsigned GELU_OUT_WIDTH       = 32;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        GELU     = 2'd1,
        RELU     = 2'd2,
        RSVD     = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } act_state_e;

    typedef struct packed {
        logic [7:0]           mult;
        logic [4:0]           shift;
        logic signed [WI-1:0] add;
    } requant_cfg_t;

endpackage

// File: rtl/ita_gelu.sv
// ita_gelu
//   Integer GELU for one lane, polynomial erf approximation:
//     L(x)    = sign(x) * ((min(|x|, -b) + b)^2 + c)
//     gelu(x) = x * (L(x) + one)
//   b is expected to be negative (the clip point of the polynomial).
//   Purely combinational; the caller registers the result.
// Ports
//   data_i : signed WI-bit input lane
//   one_i  : signed constant "one" in the erf fixed-point scale
//   b_i    : signed polynomial offset / clip point
//   c_i    : signed polynomial constant
//   data_o : signed GELU_OUT_WIDTH-bit result (wraps if constants overflow it)
module ita_gelu
    import ita_package::*;
(
    input  logic signed [WI-1:0]                   data_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] one_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] b_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] c_i,
    output logic signed [GELU_OUT_WIDTH-1:0]       data_o
);

    // Wide enough for the squared term plus the constant without overflow.
    localparam int unsigned IW = 2 * GELU_CONSTANTS_WIDTH + 4;

    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] abs_x;
    logic signed [IW-1:0] neg_b;
    logic signed [IW-1:0] clip;
    logic signed [IW-1:0] base;
    logic signed [IW-1:0] poly;
    logic signed [IW-1:0] erf;
    logic signed [IW-1:0] prod;

    always_comb begin
        x_ext  = IW'(data_i);
        abs_x  = data_i[WI-1] ? -x_ext : x_ext;
        neg_b  = -IW'(b_i);
        clip   = (abs_x > neg_b) ? neg_b : abs_x;
        base   = clip + IW'(b_i);
        poly   = base * base + IW'(c_i);
        erf    = data_i[WI-1] ? -poly : poly;
        prod   = x_ext * (erf + IW'(one_i));
        data_o = prod[GELU_OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/ita_activation_ctrl.sv
// ita_activation_ctrl
//   Sequenced activation unit: one-shot config, then a stream of N-lane
//   beats through a 3-stage pipeline (S0 input, S1 activation, S2 requant),
//   completion pulse after the last beat leaves the output.
// Build option
//   ITA_ACT_RELU_EN : when defined, mode 2 computes ReLU; otherwise mode 2
//                     (and reserved mode 3) pass the lane through unchanged.
// Ports
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o : config handshake, accepted only in IDLE
//   cfg_mode_i                : 0 identity, 1 GELU, 2 ReLU, 3 identity
//   cfg_one_i/b_i/c_i         : GELU constants
//   cfg_rq_mult_i/shift_i/add_i : requantization parameters
//   cfg_len_i                 : beats in the job (0 means 1)
//   in_valid_i / in_ready_o / in_data_i    : input beat stream
//   out_valid_o / out_ready_i / out_data_o : output beat stream
//   busy_o                    : high outside IDLE
//   done_o                    : one-cycle completion pulse
//   state_o                   : current sequencer state (act_state_e encoding)
// Handshake semantics: a beat transfers on a rising clock edge where valid
//   and ready are both high; a producer holding valid keeps its data stable
//   until that edge, and ready never depends on the same interface's valid.
module ita_activation_ctrl
    import ita_package::*;
#(
    parameter int unsigned N     = ita_package::N,
    parameter int unsigned LEN_W = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   cfg_valid_i,
    output logic                                   cfg_ready_o,
    input  logic [1:0]                             cfg_mode_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] cfg_one_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] cfg_b_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] cfg_c_i,
    input  logic [7:0]                             cfg_rq_mult_i,
    input  logic [4:0]                             cfg_rq_shift_i,
    input  logic signed [WI-1:0]                   cfg_rq_add_i,
    input  logic [LEN_W-1:0]                       cfg_len_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [N*WI-1:0]                        in_data_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [N*WI-1:0]                        out_data_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [1:0]                             state_o
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (WI - 1)) - 48'sd1;
    localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (WI - 1));

    logic [1:0] state_q, state_d;

    // Latched job configuration, frozen until the sequencer is back in IDLE.
    act_mode_e                          mode_q;
    logic signed [GELU_CONSTANTS_WIDTH-1:0] one_q, b_q, c_q;
    requant_cfg_t                       rq_cfg_q;
    logic [LEN_W-1:0]                   rem_q;

    logic s0_v, s0_last, s1_v, s1_last, s2_v, s2_last;
    logic signed [WI-1:0]             s0_d [N];
    logic signed [GELU_OUT_WIDTH-1:0] s1_d [N];
    logic signed [WI-1:0]             s2_d [N];

    logic signed [GELU_OUT_WIDTH-1:0] gelu_d [N];
    logic signed [GELU_OUT_WIDTH-1:0] act_d  [N];
    logic signed [47:0]               rq_p   [N];
    logic signed [47:0]               rq_r   [N];
    logic signed [47:0]               rq_s   [N];
    logic signed [WI-1:0]             rq_d   [N];

    logic s0_free, s1_free, s2_free;
    logic cfg_fire, in_fire, out_fire;

    // A stage can take new content when it is empty or its content moves on.
    assign s2_free  = !s2_v || out_ready_i;
    assign s1_free  = !s1_v || s2_free;
    assign s0_free  = !s0_v || s1_free;

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign in_ready_o  = (state_q == ST_RUN) && s0_free;
    assign out_valid_o = s2_v;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign state_o     = state_q;

    assign cfg_fire = cfg_valid_i && cfg_ready_o;
    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_fire) state_d = ST_RUN;
            ST_RUN:   if (in_fire && rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (out_fire && s2_last) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mode_q   <= IDENTITY;
            one_q    <= '0;
            b_q      <= '0;
            c_q      <= '0;
            rq_cfg_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_fire) begin
                mode_q         <= act_mode_e'(cfg_mode_i);
                one_q          <= cfg_one_i;
                b_q            <= cfg_b_i;
                c_q            <= cfg_c_i;
                rq_cfg_q.mult  <= cfg_rq_mult_i;
                rq_cfg_q.shift <= cfg_rq_shift_i;
                rq_cfg_q.add   <= cfg_rq_add_i;
                rem_q          <= (cfg_len_i == '0) ? LEN_W'(1) : cfg_len_i;
            end else if (in_fire) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        ita_gelu u_gelu (
            .data_i (s0_d[i]),
            .one_i  (one_q),
            .b_i    (b_q),
            .c_i    (c_q),
            .data_o (gelu_d[i])
        );
        assign out_data_o[i*WI +: WI] = s2_d[i];
    end

    // Activation select between S0 and S1.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            act_d[i] = GELU_OUT_WIDTH'(s0_d[i]);
            case (mode_q)
                GELU: act_d[i] = gelu_d[i];
`ifdef ITA_ACT_RELU_EN
                RELU: if (s0_d[i][WI-1]) act_d[i] = '0;
`endif
                default: ;
            endcase
        end
    end

    // Requantization between S1 and S2: scale, round-half-up shift, offset,
    // then clamp to the signed WI-bit range.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rq_p[i] = 48'(s1_d[i]) * $signed({40'd0, rq_cfg_q.mult});
            if (rq_cfg_q.shift != 5'd0)
                rq_p[i] = rq_p[i] + (48'sd1 <<< (rq_cfg_q.shift - 5'd1));
            rq_r[i] = rq_p[i] >>> rq_cfg_q.shift;
            rq_s[i] = rq_r[i] + 48'($signed(rq_cfg_q.add));
            if (rq_s[i] > SAT_MAX)
                rq_s[i] = SAT_MAX;
            else if (rq_s[i] < SAT_MIN)
                rq_s[i] = SAT_MIN;
            rq_d[i] = rq_s[i][WI-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_v    <= 1'b0;
            s0_last <= 1'b0;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            for (int i = 0; i < N; i++) begin
                s0_d[i] <= '0;
                s1_d[i] <= '0;
                s2_d[i] <= '0;
            end
        end else begin
            if (s0_free) begin
                s0_v    <= in_fire;
                s0_last <= in_fire && (rem_q == LEN_W'(1));
                if (in_fire)
                    for (int i = 0; i < N; i++) s0_d[i] <= in_data_i[i*WI +: WI];
            end
            if (s1_free) begin
                s1_v    <= s0_v;
                s1_last <= s0_v && s0_last;
                if (s0_v)
                    for (int i = 0; i < N; i++) s1_d[i] <= act_d[i];
            end
            // S2 only reloads when free, so held output data stays stable.
            if (s2_free) begin
                s2_v    <= s1_v;
                s2_last <= s1_v && s1_last;
                if (s1_v)
                    for (int i = 0; i < N; i++) s2_d[i] <= rq_d[i];
            end
        end
    end

endmodule
